fft_twiddle_gen: RTL and testbench
==================================

# fft_twiddle_gen

Twiddle-factor source for the FFT2048 datapath. It produces the W_N^k stream that drives the 16-bit twiddle operands (B_r/B_i) of the butterfly complex multiplier for one radix-2 DIF stage. Twiddles are signed Q1.14 with 1.0 = 16384, which matches the multiplier's 2^14 rounding shift. Storage is a quarter-wave cosine ROM expanded by symmetry, with a valid/ready output handshake.

## Interface
- N_LOG2, 11: log2 of FFT size N (N = 2048).
- TW_WIDTH, 16: signed twiddle width.
- FRAC, 14: fraction bits; TW_ONE = 1<<FRAC.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a stage sequence; sampled only when idle.
- stage  in  4  stage index s, 0..N_LOG2-1; sampled with start.
- busy  out  1  sequence in progress.
- tw_valid  out  1  tw_* outputs hold a twiddle.
- tw_ready  in  1  consumer accepts; transfer = tw_valid & tw_ready.
- tw_r  out  TW_WIDTH  real part, cos(2πk/N)·TW_ONE, rounded.
- tw_i  out  TW_WIDTH  imaginary part, −sin(2πk/N)·TW_ONE, rounded.
- tw_idx  out  N_LOG2-1  exponent k of the current twiddle.
- tw_last  out  1  final twiddle of the sequence; qualified by tw_valid.

## Operation
- Idle with start=1 and stage < N_LOG2: latch s and set busy. Idle with start=1 and stage ≥ N_LOG2: drop the request; busy stays 0. start while busy: ignored.
- Per stage, emit exactly N/2 twiddles, m = 0..N/2−1, with k = (m mod (N>>(s+1))) << s, so k < N/2.
- Quarter ROM Q[a] = round(TW_ONE·cos(2πa/N)), a = 0..N/4 (N/4+1 entries, values 0..16384).
- Expansion for k ≤ N/4: tw_r = Q[k], tw_i = −Q[N/4−k].
- Expansion for k > N/4: tw_r = −Q[N/2−k], tw_i = −Q[k−N/4].
- Two ROM addresses are read per cycle. Negation is exact; −16384 fits in 16 bits; no saturation is needed.
- Pipeline has three steps: P0 index counter/address generation, P1 registered ROM read plus region/sign flags, P2 output register with negation.
- Stall rule: enable = ~(tw_valid & ~tw_ready). All three steps advance only on enable. tw_* stays stable while stalled, with no skipped or duplicated twiddles.
- FSM states:
  - IDLE → RUN on an accepted start.
  - RUN: issue m = 0..N/2−1 on enabled cycles, then → DRAIN.
  - DRAIN: wait for the transfer with tw_last=1, then → IDLE.
- Reset at any time (including mid-sequence) returns the FSM to IDLE, flushes the pipeline, and clears all outputs on the next edge.

## Timing
- Reset values: busy=0, tw_valid=0, tw_r=0, tw_i=0, tw_idx=0, tw_last=0.
- start accepted at edge T: busy=1 from T+1. The first tw_valid is at T+3 (latency 2 from index issue) if tw_ready has been high.
- Throughput is one twiddle per cycle while tw_ready=1; N/2 consecutive valid cycles when never stalled.
- tw_last=1 only on twiddle m = N/2−1.
- busy drops the cycle after the tw_last transfer. A start presented in that same transfer cycle is ignored because busy is still 1. A start presented the following cycle is accepted.
- tw_valid may rise regardless of tw_ready. It never falls without a transfer, except on reset.

## Structure
- Shared package fft_pkg holds N_LOG2, FRAC, TW_ONE, QROM_DEPTH = N/4+1, and the twiddle width. These are also used by the multiplier and butterfly.
- Sub-module fft_tw_qrom holds Q[] with two synchronous read ports and a read enable (for stall). Its contents are generated from fft_pkg constants.
- FSM, counter, region/sign logic, and output register live in fft_twiddle_gen.

## Test plan
- Stage 0, tw_ready=1:
  - k=0 → (16384, 0)
  - k=1 → (16384, −50)
  - k=512 → (0, −16384)
  - k=1023 → (−16384, −50)
  - 1024 outputs, tw_last only on the final one, first valid 3 cycles after start.
- Stage 1: m=256 → k=512 → (0, −16384); m=512 → k=0 → (16384, 0); tw_idx pattern repeats every 512.
- Stage 10: all 1024 outputs equal (16384, 0) with tw_idx=0.
- Backpressure: drop tw_ready for 5 cycles at m=100 → outputs frozen at m=100. The resumed stream has no gap or duplicate, and the full sequence matches a golden model.
- Protocol edges:
  - start with stage=11 → busy stays 0.
  - start during RUN → ignored.
  - start in the cycle after the tw_last transfer → new sequence accepted.
- Reset: rst_n=0 at m=300 → next edge has all outputs 0 and the FSM idle. A fresh start afterwards restarts from m=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT2048 constants and types used by the twiddle source, multiplier and butterfly.
// qrom_value() defines the quarter-wave cosine table contents in Q1.14.
package fft_pkg;

  localparam int  N_LOG2     = 11;
  localparam int  FFT_N      = 1 << N_LOG2;
  localparam int  TW_WIDTH   = 16;
  localparam int  FRAC       = 14;
  localparam int  TW_ONE     = 1 << FRAC;
  localparam int  QROM_DEPTH = FFT_N / 4 + 1;
  localparam int  TW_IDX_W   = N_LOG2 - 1;
  localparam int  TW_HALF    = FFT_N / 2;
  localparam int  TW_QUARTER = FFT_N / 4;
  localparam real TW_PI      = 3.14159265358979323846;

  typedef logic [FRAC:0]         qrom_word_t;
  typedef logic [TW_IDX_W-1:0]   tw_idx_t;
  typedef logic [TW_WIDTH-1:0]   tw_word_t;

  typedef enum logic [1:0] {
    TW_IDLE  = 2'd0,
    TW_RUN   = 2'd1,
    TW_DRAIN = 2'd2
  } tw_state_e;

  // round(TW_ONE * cos(2*pi*a/N)); all table entries are non-negative
  function automatic qrom_word_t qrom_value(input int a);
    real ang;
    ang = 2.0 * TW_PI * real'(a) / real'(FFT_N);
    return qrom_word_t'(int'($floor(real'(TW_ONE) * $cos(ang) + 0.5)));
  endfunction

endpackage

// File: rtl/fft_tw_qrom.sv
// Quarter-wave cosine ROM, N/4+1 entries, two synchronous read ports.
// Reads advance only when rd_en_i is high so the data holds through a stall.
module fft_tw_qrom
  import fft_pkg::*;
(
  input  logic       clk_i,
  input  logic       rd_en_i,
  input  tw_idx_t    addr_a_i,
  input  tw_idx_t    addr_b_i,
  output qrom_word_t data_a_o,
  output qrom_word_t data_b_o
);

  qrom_word_t rom_s [QROM_DEPTH];

  for (genvar a = 0; a < QROM_DEPTH; a++) begin : g_rom
    assign rom_s[a] = qrom_value(a);
  end

  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      data_a_o <= rom_s[addr_a_i];
      data_b_o <= rom_s[addr_b_i];
    end
  end

endmodule

// File: rtl/fft_twiddle_gen.sv
// Twiddle stream W_N^k for one radix-2 DIF stage: index counter (P0), ROM read and
// region flags (P1), signed output register (P2), all gated by the output handshake.
module fft_twiddle_gen
  import fft_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [3:0]                 stage,
  output logic                       busy,
  output logic                       tw_valid,
  input  logic                       tw_ready,
  output logic signed [TW_WIDTH-1:0] tw_r,
  output logic signed [TW_WIDTH-1:0] tw_i,
  output logic [N_LOG2-2:0]          tw_idx,
  output logic                       tw_last
);

  localparam tw_idx_t M_LAST  = tw_idx_t'(TW_HALF - 1);
  localparam tw_idx_t QUARTER = tw_idx_t'(TW_QUARTER);

  tw_state_e  state_q, state_d;
  tw_idx_t    m_q, m_d;
  logic [3:0] stage_q, stage_d;
  logic       en_s, issue_s;

  tw_idx_t    k_s, addr_a_s, addr_b_s;
  logic       neg_r_s;
  qrom_word_t qa_s, qb_s;

  logic       v1_q, neg1_q, last1_q;
  tw_idx_t    k1_q;

  logic       tw_valid_q, tw_last_q;
  tw_word_t   tw_r_q, tw_i_q;
  tw_idx_t    tw_idx_q;
  tw_word_t   qa_ext_s, qb_ext_s;

  assign en_s = ~(tw_valid_q & ~tw_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TW_IDLE;
      m_q     <= tw_idx_t'(0);
      stage_q <= 4'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    stage_d = stage_q;
    issue_s = 1'b0;
    case (state_q)
      TW_IDLE: begin
        if (start && (stage < 4'(N_LOG2))) begin
          state_d = TW_RUN;
          m_d     = tw_idx_t'(0);
          stage_d = stage;
        end else begin
          state_d = TW_IDLE;
        end
      end
      TW_RUN: begin
        if (en_s) begin
          issue_s = 1'b1;
          if (m_q == M_LAST) begin
            state_d = TW_DRAIN;
            m_d     = tw_idx_t'(0);
          end else begin
            m_d = m_q + tw_idx_t'(1);
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      TW_DRAIN: begin
        if (tw_valid_q && tw_ready && tw_last_q) begin
          state_d = TW_IDLE;
        end else begin
          state_d = TW_DRAIN;
        end
      end
      default: state_d = TW_IDLE;
    endcase
  end

  // (m mod (N>>(s+1))) << s equals (m << s) truncated to the index width
  always_comb begin
    k_s = m_q << stage_q;
    if (k_s <= QUARTER) begin
      addr_a_s = k_s;
      addr_b_s = QUARTER - k_s;
      neg_r_s  = 1'b0;
    end else begin
      addr_a_s = tw_idx_t'(TW_HALF - 32'(k_s));
      addr_b_s = k_s - QUARTER;
      neg_r_s  = 1'b1;
    end
  end

  fft_tw_qrom u_qrom (
    .clk_i    (clk),
    .rd_en_i  (en_s),
    .addr_a_i (addr_a_s),
    .addr_b_i (addr_b_s),
    .data_a_o (qa_s),
    .data_b_o (qb_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      neg1_q  <= 1'b0;
      last1_q <= 1'b0;
      k1_q    <= tw_idx_t'(0);
    end else if (en_s) begin
      v1_q    <= issue_s;
      neg1_q  <= neg_r_s;
      last1_q <= issue_s && (m_q == M_LAST);
      k1_q    <= k_s;
    end
  end

  assign qa_ext_s = tw_word_t'(qa_s);
  assign qb_ext_s = tw_word_t'(qb_s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tw_valid_q <= 1'b0;
      tw_last_q  <= 1'b0;
      tw_r_q     <= tw_word_t'(0);
      tw_i_q     <= tw_word_t'(0);
      tw_idx_q   <= tw_idx_t'(0);
    end else if (en_s) begin
      tw_valid_q <= v1_q;
      tw_last_q  <= v1_q & last1_q;
      tw_r_q     <= neg1_q ? (tw_word_t'(0) - qa_ext_s) : qa_ext_s;
      tw_i_q     <= tw_word_t'(0) - qb_ext_s;
      tw_idx_q   <= k1_q;
    end
  end

  assign busy     = (state_q != TW_IDLE);
  assign tw_valid = tw_valid_q;
  assign tw_last  = tw_last_q;
  assign tw_r     = tw_r_q;
  assign tw_i     = tw_i_q;
  assign tw_idx   = tw_idx_q;

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Randomized self-checking bench for fft_twiddle_gen: a trig-based model queue is
// compared against every transfer, plus directed timing, stall, protocol and reset checks.
module tb_fft_twiddle_gen;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        stage = 4'd0;
  logic              busy;
  logic              tw_valid;
  logic              tw_ready = 1'b1;
  logic signed [15:0] tw_r;
  logic signed [15:0] tw_i;
  logic [9:0]        tw_idx;
  logic              tw_last;

  fft_twiddle_gen u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stage    (stage),
    .busy     (busy),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .tw_r     (tw_r),
    .tw_i     (tw_i),
    .tw_idx   (tw_idx),
    .tw_last  (tw_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int r;
    int i;
    bit last;
  } tw_exp_t;

  tw_exp_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  xfer_total = 0;
  int  seq_edges = 0;
  bit  rdy_rand = 1'b0;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    else return -int'($floor(-x + 0.5));
  endfunction

  function automatic int exp_r(input int k);
    return rnd(16384.0 * $cos(2.0 * 3.14159265358979323846 * real'(k) / 2048.0));
  endfunction

  function automatic int exp_i(input int k);
    return -rnd(16384.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 2048.0));
  endfunction

  function automatic void push_model(input int s);
    tw_exp_t e;
    for (int m = 0; m < 1024; m++) begin
      e.k    = (m % (2048 >> (s + 1))) << s;
      e.r    = exp_r(e.k);
      e.i    = exp_i(e.k);
      e.last = (m == 1023);
      exp_q.push_back(e);
    end
  endfunction

  // Random backpressure source, active only while rdy_rand is set
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_rand) tw_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Per-cycle checker: transfers against the model queue, stability while stalled
  initial begin
    bit pv, pr, p_last;
    logic signed [15:0] p_r, p_i;
    logic [9:0] p_idx;
    tw_exp_t e;
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("stall_hold", int'(tw_valid && tw_r == p_r && tw_i == p_i &&
                                   tw_idx == p_idx && tw_last == p_last), 1);
        end
        if (tw_valid && tw_ready) begin
          xfer_total++;
          if (exp_q.size() == 0) begin
            check("unexpected_xfer_idx", int'(tw_idx), -1);
          end else begin
            e = exp_q.pop_front();
            check("tw_idx", int'(tw_idx), e.k);
            check("tw_r", int'(tw_r), e.r);
            check("tw_i", int'(tw_i), e.i);
            check("tw_last", int'(tw_last), int'(e.last));
            if (e.k == 0)    begin check("pin_k0_r", int'(tw_r), 16384);     check("pin_k0_i", int'(tw_i), 0);      end
            if (e.k == 1)    begin check("pin_k1_r", int'(tw_r), 16384);     check("pin_k1_i", int'(tw_i), -50);    end
            if (e.k == 512)  begin check("pin_k512_r", int'(tw_r), 0);       check("pin_k512_i", int'(tw_i), -16384); end
            if (e.k == 1023) begin check("pin_k1023_r", int'(tw_r), -16384); check("pin_k1023_i", int'(tw_i), -50);  end
          end
        end
        pv = tw_valid;
        pr = tw_ready;
        p_r = tw_r;
        p_i = tw_i;
        p_idx = tw_idx;
        p_last = tw_last;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) check("idle_timeout", int'(busy), 0);
  endtask

  // Accept a start and optionally check busy/valid latency from the accepting edge
  task automatic start_seq(input int s, input bit timing);
    start = 1'b1;
    stage = 4'(s);
    if (s < 11) push_model(s);
    @(posedge clk);
    #1;
    start = 1'b0;
    seq_edges = 0;
    check("busy_after_start", int'(busy), int'(s < 11));
    if (timing) begin
      @(posedge clk);
      #1;
      seq_edges++;
      check("valid_edge1", int'(tw_valid), 0);
      @(posedge clk);
      #1;
      seq_edges++;
      check("valid_edge2", int'(tw_valid), 1);
    end
  endtask

  task automatic finish_seq(input int exp_edges);
    while (busy && seq_edges < 20000) begin
      @(posedge clk);
      #1;
      seq_edges++;
    end
    if (busy) check("seq_timeout", int'(busy), 0);
    if (exp_edges >= 0) check("seq_edges", seq_edges, exp_edges);
  endtask

  task automatic wait_xfers(input int base, input int cnt);
    int n;
    n = 0;
    while ((xfer_total - base) < cnt && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("xfer_reach", xfer_total - base, cnt);
  endtask

  initial begin
    int base, n, s;

    check("model_k0_r", exp_r(0), 16384);
    check("model_k0_i", exp_i(0), 0);
    check("model_k1_i", exp_i(1), -50);
    check("model_k512_r", exp_r(512), 0);
    check("model_k512_i", exp_i(512), -16384);
    check("model_k1023_r", exp_r(1023), -16384);
    check("model_k1023_i", exp_i(1023), -50);

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(tw_valid), 0);
    check("rst_r", int'(tw_r), 0);
    check("rst_i", int'(tw_i), 0);
    check("rst_idx", int'(tw_idx), 0);
    check("rst_last", int'(tw_last), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stage 0 and stage 10, never stalled: exactly N/2 back-to-back transfers
    start_seq(0, 1'b1);
    finish_seq(1026);
    start_seq(10, 1'b1);
    finish_seq(1026);

    // Stage 1 under random backpressure
    rdy_rand = 1'b1;
    start_seq(1, 1'b1);
    finish_seq(-1);
    rdy_rand = 1'b0;
    tw_ready = 1'b1;
    @(posedge clk);
    #1;

    // Stall for 5 cycles with m=100 on the outputs
    base = xfer_total;
    start_seq(0, 1'b0);
    wait_xfers(base, 100);
    tw_ready = 1'b0;
    check("bp_idx_enter", int'(tw_idx), 100);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_frozen_idx", int'(tw_idx), 100);
      check("bp_frozen_valid", int'(tw_valid), 1);
    end
    tw_ready = 1'b1;
    wait_idle();

    // Out-of-range stage request is dropped
    start = 1'b1;
    stage = 4'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("bad_stage_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    check("bad_stage_busy2", int'(busy), 0);

    // Start while running is ignored
    start_seq(4, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    stage = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("run_start_busy", int'(busy), 1);
    wait_idle();

    // Start in the tw_last transfer cycle is ignored, the next cycle is accepted
    start_seq(10, 1'b0);
    n = 0;
    while (!(tw_valid && tw_last) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("saw_last", int'(tw_valid && tw_last), 1);
    start = 1'b1;
    stage = 4'd5;
    @(posedge clk);
    #1;
    check("busy_after_last", int'(busy), 0);
    stage = 4'd3;
    push_model(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_busy", int'(busy), 1);
    wait_idle();

    // Reset in the middle of a sequence, then a fresh sequence from m=0
    base = xfer_total;
    start_seq(0, 1'b0);
    wait_xfers(base, 300);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(tw_valid), 0);
    check("mid_rst_r", int'(tw_r), 0);
    check("mid_rst_i", int'(tw_i), 0);
    check("mid_rst_idx", int'(tw_idx), 0);
    check("mid_rst_last", int'(tw_last), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_seq(0, 1'b1);
    finish_seq(1026);

    // Random stages with random backpressure
    rdy_rand = 1'b1;
    for (int j = 0; j < 3; j++) begin
      s = $urandom_range(0, 10);
      start_seq(s, 1'b1);
      finish_seq(-1);
      @(posedge clk);
      #1;
    end
    rdy_rand = 1'b0;
    tw_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("model_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
